// File: rtl/param_sram_pkg.sv
// Shared types and helpers for the param_sram byte-lane SRAM.
// PARAM_SRAM_PARITY_EN (see param_sram) selects per-lane even-parity storage.
package param_sram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    function automatic logic byte_par(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/param_sram_array.sv
// Lane-addressed storage with per-lane write enables and a registered read.
// Out-of-range addresses never touch storage and read back as zero.
module param_sram_array #(
    parameter int LANE_W = 8,
    parameter int NLANE  = 1,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [NLANE-1:0][LANE_W-1:0]  wdata,
    input  logic [NLANE-1:0]              wbe,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [NLANE-1:0][LANE_W-1:0]  rdata
);

    localparam int AW1 = ADDR_W + 1;

    logic [NLANE-1:0][LANE_W-1:0] mem [DEPTH];
    logic                         wok;
    logic                         rok;

    assign wok = {1'b0, waddr} < AW1'(DEPTH);
    assign rok = {1'b0, raddr} < AW1'(DEPTH);

    always_ff @(posedge clk) begin
        if (we && wok) begin
            for (int i = 0; i < NLANE; i++) begin
                if (wbe[i]) mem[waddr][i] <= wdata[i];
            end
        end
    end

    // Only the read register is reset; the array content is set by the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rok ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/param_sram.sv
// Byte-enable SRAM with a clear sweep FSM and valid/ready request port.
// Define PARAM_SRAM_PARITY_EN to store and check even parity per byte lane.
module param_sram
    import param_sram_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 5,
    parameter  int DEPTH  = 1 << ADDR_W,
    localparam int BE_W   = DATA_W / BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              init_busy,
    output logic              rd_perr
);

`ifdef PARAM_SRAM_PARITY_EN
    localparam int LANE_W = BYTE_W + 1;
`else
    localparam int LANE_W = BYTE_W;
`endif
    localparam int CNT_W = ADDR_W + 1;

    state_t                       state;
    logic [CNT_W-1:0]             cnt;
    logic                         acc;
    logic                         in_range;
    logic                         arr_we;
    logic                         arr_re;
    logic [ADDR_W-1:0]            arr_waddr;
    logic [BE_W-1:0]              arr_be;
    logic [BE_W-1:0][LANE_W-1:0]  arr_wdata;
    logic [BE_W-1:0][LANE_W-1:0]  arr_rdata;

    assign req_ready = (state == RUN) && !clr;
    assign init_busy = (state == INIT);
    assign acc       = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < CNT_W'(DEPTH);
    assign arr_re    = acc && !req_we;

    always_comb begin
        arr_we    = acc && req_we && in_range;
        arr_waddr = req_addr;
        arr_be    = req_be;
        arr_wdata = '0;
        for (int i = 0; i < BE_W; i++) begin
            arr_wdata[i][BYTE_W-1:0] = req_wdata[i*BYTE_W +: BYTE_W];
`ifdef PARAM_SRAM_PARITY_EN
            arr_wdata[i][BYTE_W] = byte_par(req_wdata[i*BYTE_W +: BYTE_W]);
`endif
        end
        // Zero data carries zero even-parity, so the sweep writes all-zero lanes.
        if (state == INIT) begin
            arr_we    = 1'b1;
            arr_waddr = cnt[ADDR_W-1:0];
            arr_be    = '1;
            arr_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= arr_re;
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DEPTH - 1)) state <= RUN;
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                end
            endcase
        end
    end

    param_sram_array #(
        .LANE_W (LANE_W),
        .NLANE  (BE_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_arr (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .wbe    (arr_be),
        .re     (arr_re),
        .raddr  (req_addr),
        .rdata  (arr_rdata)
    );

    always_comb begin
        for (int i = 0; i < BE_W; i++) begin
            rd_data[i*BYTE_W +: BYTE_W] = arr_rdata[i][BYTE_W-1:0];
        end
    end

`ifdef PARAM_SRAM_PARITY_EN
    logic perr;

    always_comb begin
        perr = 1'b0;
        for (int i = 0; i < BE_W; i++) begin
            perr |= byte_par(arr_rdata[i][BYTE_W-1:0]) != arr_rdata[i][BYTE_W];
        end
    end

    assign rd_perr = rd_valid && perr;
`else
    assign rd_perr = 1'b0;
`endif

endmodule

// File: tb/tb_param_sram.sv
// Randomized bench for param_sram: an 8-bit default instance and a
// 32-bit, DEPTH=20 instance, both checked against array models.
module tb_param_sram;

    logic clk;
    logic rst_n;

    logic        a_clr, a_valid, a_ready, a_we, a_rv, a_busy, a_perr;
    logic [4:0]  a_addr;
    logic [7:0]  a_wdata, a_rd;
    logic [0:0]  a_be;

    logic        b_clr, b_valid, b_ready, b_we, b_rv, b_busy, b_perr;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata, b_rd;
    logic [3:0]  b_be;

    int n_chk;
    int n_err;

    logic [7:0]  m0 [32];
    logic [31:0] m1 [20];
    logic [7:0]  last0;
    logic [31:0] last1;

    param_sram d0 (
        .clk(clk), .rst_n(rst_n), .clr(a_clr),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be),
        .rd_valid(a_rv), .rd_data(a_rd), .init_busy(a_busy),
        .rd_perr(a_perr)
    );

    param_sram #(.DATA_W(32), .ADDR_W(5), .DEPTH(20)) d1 (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be),
        .rd_valid(b_rv), .rd_data(b_rd), .init_busy(b_busy),
        .rd_perr(b_perr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) m0[i] = 8'h00;
        for (int i = 0; i < 20; i++) m1[i] = 32'h0;
        last0 = 8'h00;
        last1 = 32'h0;
    endtask

    task automatic op0(input bit we, input logic [4:0] addr,
                       input logic [7:0] d, input bit be);
        a_valid = 1'b1; a_we = we; a_addr = addr;
        a_wdata = d; a_be = be;
        @(posedge clk); #1;
        a_valid = 1'b0; a_we = 1'b0;
        if (we) begin
            if (be) m0[addr] = d;
            check("a_wr_rv", a_rv, 0);
        end else begin
            last0 = m0[addr];
            check("a_rv", a_rv, 1);
            check("a_rd", a_rd, last0);
            check("a_perr", a_perr, 0);
        end
    endtask

    task automatic op1(input bit we, input logic [4:0] addr,
                       input logic [31:0] d, input logic [3:0] be);
        b_valid = 1'b1; b_we = we; b_addr = addr;
        b_wdata = d; b_be = be;
        @(posedge clk); #1;
        b_valid = 1'b0; b_we = 1'b0;
        if (we) begin
            if (addr < 20) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) m1[addr][i*8 +: 8] = d[i*8 +: 8];
            end
            check("b_wr_rv", b_rv, 0);
        end else begin
            last1 = (addr < 20) ? m1[addr] : 32'h0;
            check("b_rv", b_rv, 1);
            check("b_rd", b_rd, last1);
            check("b_perr", b_perr, 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("a_idle_rv", a_rv, 0);
            check("a_hold", a_rd, last0);
            check("b_idle_rv", b_rv, 0);
            check("b_hold", b_rd, last1);
        end
    endtask

    // Counts edges until req_ready; init_busy must be 1 until then.
    task automatic wait_rdy(input bit dev, input int exp, input string tag);
        int  k;
        bit  busy_ok;
        k = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (dev ? b_ready : a_ready) begin
                k = i;
                break;
            end
            if (!(dev ? b_busy : a_busy)) busy_ok = 1'b0;
        end
        check(tag, k, exp);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_done"}, dev ? b_busy : a_busy, 0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        clk = 1'b0; rst_n = 1'b0;
        a_clr = 0; a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_clr = 0; b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
        clear_models();

        #1;
        check("rst_a_busy", a_busy, 1);
        check("rst_a_ready", a_ready, 0);
        check("rst_a_rv", a_rv, 0);
        check("rst_a_rd", a_rd, 0);
        check("rst_a_perr", a_perr, 0);
        check("rst_b_rd", b_rd, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        fork
            wait_rdy(1'b0, 32, "a_init_len");
            wait_rdy(1'b1, 20, "b_init_len");
        join

        for (int i = 0; i < 32; i++) op0(1'b0, 5'(i), 8'h00, 1'b0);

        op0(1'b1, 5'd3, 8'hA5, 1'b1);
        op0(1'b0, 5'd3, 8'h00, 1'b0);
        check("a5_direct", a_rd, 8'hA5);
        op0(1'b1, 5'd3, 8'h3C, 1'b0);
        op0(1'b0, 5'd3, 8'h00, 1'b0);
        idle(2);

        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 4);
            if (r == 0) idle(1);
            else op0(r == 1, 5'($urandom_range(0, 31)), 8'($urandom),
                     ($urandom % 4) != 0);
        end

        op1(1'b1, 5'd4, 32'h11223344, 4'b1111);
        op1(1'b1, 5'd4, 32'hAABBCCDD, 4'b0101);
        op1(1'b0, 5'd4, 32'h0, 4'b0);
        check("be_merge", b_rd, 32'h11BB33DD);
        op1(1'b1, 5'd19, 32'hCAFEF00D, 4'b1111);
        op1(1'b1, 5'd25, 32'hDEADBEEF, 4'b1111);
        op1(1'b0, 5'd25, 32'h0, 4'b0);
        check("oor_rd", b_rd, 32'h0);
        op1(1'b0, 5'd19, 32'h0, 4'b0);
        check("edge_19", b_rd, 32'hCAFEF00D);
        op1(1'b1, 5'd19, 32'h12345678, 4'b0000);
        op1(1'b0, 5'd19, 32'h0, 4'b0);

        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 4);
            if (r == 0) idle(1);
            else op1(r == 1, 5'($urandom_range(0, 31)), $urandom,
                     4'($urandom));
        end

`ifdef PARAM_SRAM_PARITY_EN
        d0.u_arr.mem[7][0][0] = ~d0.u_arr.mem[7][0][0];
        a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd7;
        @(posedge clk); #1;
        a_valid = 1'b0;
        check("perr_rv", a_rv, 1);
        check("perr_set", a_perr, 1);
        last0 = a_rd;
        op0(1'b0, 5'd8, 8'h00, 1'b0);
`endif

        a_clr = 1'b1; a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd3;
        #1;
        check("clr_ready", a_ready, 0);
        @(posedge clk); #1;
        a_clr = 1'b0; a_valid = 1'b0;
        check("clr_noacc", a_rv, 0);
        wait_rdy(1'b0, 32, "a_clr_len");
        for (int i = 0; i < 32; i++) m0[i] = 8'h00;
        for (int i = 0; i < 32; i++) op0(1'b0, 5'(i), 8'h00, 1'b0);

        b_clr = 1'b1;
        @(posedge clk); #1;
        b_clr = 1'b0;
        fork
            wait_rdy(1'b1, 20, "b_clr_len");
            begin
                repeat (5) begin @(posedge clk); #1; end
                b_clr = 1'b1;
                @(posedge clk); #1;
                b_clr = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) m1[i] = 32'h0;
        for (int i = 0; i < 32; i++) op1(1'b0, 5'(i), 32'h0, 4'b0);

        op0(1'b1, 5'd9, 8'h5A, 1'b1);
        op1(1'b1, 5'd2, 32'h01020304, 4'b1111);
        a_clr = 1'b1;
        @(posedge clk); #1;
        a_clr = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        op1(1'b0, 5'd2, 32'h0, 4'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rv", b_rv, 0);
        check("mid_rst_rd", b_rd, 0);
        check("mid_rst_busy", b_busy, 1);
        @(negedge clk) rst_n = 1'b1;
        clear_models();
        fork
            wait_rdy(1'b0, 32, "a_rst_len");
            wait_rdy(1'b1, 20, "b_rst_len");
        join
        op0(1'b0, 5'd9, 8'h00, 1'b0);
        op1(1'b0, 5'd2, 32'h0, 4'b0);

        for (int n = 0; n < 60; n++) begin
            op0($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                8'($urandom), 1'b1);
            op1($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                $urandom, 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
